flash_nand_bus_sequencer: RTL and testbench

Cycle-level bus sequencer between the NAND FLASH command controller and the FLASH chip pins. Turns single-cycle command-latch, address-latch and data-read requests into correctly timed CLE/ALE/WE#/RE#/CE# waveforms on the 16-bit chip bus. Returns a one-cycle completion strobe per operation, and the captured data word for reads. Also synchronises the chip R/B# line for the controller.

---
 rtl/flash_nand_pkg.sv | 14 +
 rtl/flash_nand_bus_sequencer.sv | 146 ++++++++++++++
 tb/tb_flash_nand_bus_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/flash_nand_pkg.sv
// flash_nand_pkg: shared state encoding, default bus timing and NAND opcodes
package flash_nand_pkg;
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_HOLD} state_t;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_WP_DEF = 3;
  localparam int unsigned T_WH_DEF = 2;
  localparam int unsigned T_RP_DEF = 3;
  localparam int unsigned T_REH_DEF = 2;
  localparam logic [7:0] OP_RESET = 8'hFF;
  localparam logic [7:0] OP_READ_ID = 8'h90;
  localparam logic [7:0] OP_READ = 8'h00;
  localparam logic [7:0] OP_READ_CONFIRM = 8'h30;
  localparam logic [7:0] OP_STATUS = 8'h70;
endpackage

// File: rtl/flash_nand_bus_sequencer.sv
// flash_nand_bus_sequencer: turns single-cycle cmd/addr/read requests into timed NAND pin waveforms
module flash_nand_bus_sequencer
  import flash_nand_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_WP = T_WP_DEF,
  parameter int unsigned T_WH = T_WH_DEF,
  parameter int unsigned T_RP = T_RP_DEF,
  parameter int unsigned T_REH = T_REH_DEF
) (
  input  logic        i_master_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_request,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_done,
  input  logic        i_ad_request,
  input  logic [7:0]  i_ad_data,
  output logic        o_ad_done,
  input  logic        i_rd_request,
  output logic [15:0] o_rd_data,
  output logic        o_rd_data_valid,
  output logic        o_busy,
  input  logic [15:0] i_chip_data,
  output logic [15:0] o_chip_data,
  output logic        o_chip_data_out,
  output logic        o_chip_cs_n,
  output logic        o_chip_ale,
  output logic        o_chip_cle,
  output logic        o_chip_we_n,
  output logic        o_chip_re_n,
  input  logic        i_chip_ready,
  output logic        o_chip_ready
);
  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_WP = 8'(T_WP - 1);
  localparam logic [7:0] LD_WH = 8'(T_WH - 1);
  localparam logic [7:0] LD_RP = 8'(T_RP - 1);
  localparam logic [7:0] LD_REH = 8'(T_REH - 1);
  state_t state;
  logic [7:0] cnt;
  logic [15:0] rd_cap;
  logic ready_meta;
  logic last;
  assign last = (cnt == 8'd0);
  // phase sequencer: every state loads the shared down-counter on entry and leaves when it hits 0
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      rd_cap <= 16'd0;
      o_rd_data <= 16'd0;
      o_chip_data <= 16'd0;
      o_chip_data_out <= 1'b0;
      o_chip_cs_n <= 1'b1;
      o_chip_ale <= 1'b0;
      o_chip_cle <= 1'b0;
      o_chip_we_n <= 1'b1;
      o_chip_re_n <= 1'b1;
      o_busy <= 1'b0;
      o_cmd_done <= 1'b0;
      o_ad_done <= 1'b0;
      o_rd_data_valid <= 1'b0;
    end else begin
      o_cmd_done <= 1'b0;
      o_ad_done <= 1'b0;
      o_rd_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_request || i_ad_request) begin
            state <= W_SETUP;
            cnt <= LD_SETUP;
            o_chip_data <= {8'h00, i_cmd_request ? i_cmd_data : i_ad_data};
            o_chip_cle <= i_cmd_request;
            o_chip_ale <= !i_cmd_request;
            o_chip_cs_n <= 1'b0;
            o_chip_data_out <= 1'b1;
            o_busy <= 1'b1;
          end else if (i_rd_request) begin
            state <= R_SETUP;
            cnt <= LD_SETUP;
            o_chip_cs_n <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        W_SETUP: begin
          cnt <= last ? LD_WP : cnt - 8'd1;
          if (last) begin
            state <= W_PULSE;
            o_chip_we_n <= 1'b0;
          end
        end
        W_PULSE: begin
          cnt <= last ? LD_WH : cnt - 8'd1;
          if (last) begin
            state <= W_HOLD;
            o_chip_we_n <= 1'b1;
          end
        end
        W_HOLD: begin
          cnt <= last ? 8'd0 : cnt - 8'd1;
          if (last) begin
            state <= IDLE;
            o_cmd_done <= o_chip_cle;
            o_ad_done <= o_chip_ale;
            o_chip_cle <= 1'b0;
            o_chip_ale <= 1'b0;
            o_chip_cs_n <= 1'b1;
            o_chip_data_out <= 1'b0;
            o_busy <= 1'b0;
          end
        end
        R_SETUP: begin
          cnt <= last ? LD_RP : cnt - 8'd1;
          if (last) begin
            state <= R_PULSE;
            o_chip_re_n <= 1'b0;
          end
        end
        R_PULSE: begin
          cnt <= last ? LD_REH : cnt - 8'd1;
          if (last) begin
            state <= R_HOLD;
            o_chip_re_n <= 1'b1;
            rd_cap <= i_chip_data;
          end
        end
        R_HOLD: begin
          cnt <= last ? 8'd0 : cnt - 8'd1;
          if (last) begin
            state <= IDLE;
            o_rd_data <= rd_cap;
            o_rd_data_valid <= 1'b1;
            o_chip_cs_n <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // two-flop synchroniser for the asynchronous chip R/B# line
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) {o_chip_ready, ready_meta} <= 2'b00;
    else {o_chip_ready, ready_meta} <= {ready_meta, i_chip_ready};
  end
endmodule

// File: tb/tb_flash_nand_bus_sequencer.sv
// tb_flash_nand_bus_sequencer: directed table-driven check of NAND pin timing
module tb_flash_nand_bus_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic cmd_req = 1'b0, ad_req = 1'b0, rd_req = 1'b0, chip_ready = 1'b0;
  logic [7:0] cmd_d = 8'h00, ad_d = 8'h00;
  logic [15:0] word = 16'h0000;
  logic [15:0] chip_din;
  logic cmd_done, ad_done, rd_valid, busy, dout, cs_n, ale, cle, we_n, re_n, rdy;
  logic [15:0] rd_data, chip_dq;
  logic f_cmd_done, f_ad_done, f_rd_valid, f_busy, f_dout, f_cs_n, f_ale, f_cle, f_we_n, f_re_n, f_rdy;
  logic [15:0] f_rd_data, f_chip_dq;
  int checks = 0, failures = 0;
  assign chip_din = re_n ? 16'hDEAD : word;
  flash_nand_bus_sequencer dut (
    .i_master_clk(clk), .i_reset_n(rst_n),
    .i_cmd_request(cmd_req), .i_cmd_data(cmd_d), .o_cmd_done(cmd_done),
    .i_ad_request(ad_req), .i_ad_data(ad_d), .o_ad_done(ad_done),
    .i_rd_request(rd_req), .o_rd_data(rd_data), .o_rd_data_valid(rd_valid), .o_busy(busy),
    .i_chip_data(chip_din), .o_chip_data(chip_dq), .o_chip_data_out(dout),
    .o_chip_cs_n(cs_n), .o_chip_ale(ale), .o_chip_cle(cle), .o_chip_we_n(we_n), .o_chip_re_n(re_n),
    .i_chip_ready(chip_ready), .o_chip_ready(rdy)
  );
  flash_nand_bus_sequencer #(.T_SETUP(1), .T_WP(1)) fast (
    .i_master_clk(clk), .i_reset_n(rst_n),
    .i_cmd_request(cmd_req), .i_cmd_data(cmd_d), .o_cmd_done(f_cmd_done),
    .i_ad_request(ad_req), .i_ad_data(ad_d), .o_ad_done(f_ad_done),
    .i_rd_request(rd_req), .o_rd_data(f_rd_data), .o_rd_data_valid(f_rd_valid), .o_busy(f_busy),
    .i_chip_data(chip_din), .o_chip_data(f_chip_dq), .o_chip_data_out(f_dout),
    .o_chip_cs_n(f_cs_n), .o_chip_ale(f_ale), .o_chip_cle(f_cle), .o_chip_we_n(f_we_n), .o_chip_re_n(f_re_n),
    .i_chip_ready(chip_ready), .o_chip_ready(f_rdy)
  );
  // op: 0 cmd, 1 ad, 2 rd, 3 cmd+rd, 4 ad+rd, 5 cmd+ad
  typedef struct {
    int op;
    logic [7:0] d;
    logic [15:0] w;
    logic [15:0] exp_cd;
    logic [15:0] exp_rd;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] exp_pins(input bit w, input bit c, input bit a, input bit r, input int j);
    bit act = j <= 7;
    bit lo = j >= 3 && j <= 5;
    return {!act, c && act, a && act, !(w && lo), !(r && lo), w && act, act, c && j == 8, a && j == 8, r && j == 8};
  endfunction
  task automatic run_vec(input vec_t v, input logic [15:0] prev_rd, input int idx);
    bit c = v.op inside {0, 3, 5};
    bit a = v.op inside {1, 4};
    bit r = v.op == 2;
    cmd_req = v.op inside {0, 3, 5};
    ad_req = v.op inside {1, 4, 5};
    rd_req = v.op inside {2, 3, 4};
    cmd_d = v.d;
    ad_d = (v.op == 5) ? 8'h55 : v.d;
    word = v.w;
    @(posedge clk);
    #1 {cmd_req, ad_req, rd_req} = 3'b000;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_pins_c%0d", idx, j),
          {22'd0, cs_n, cle, ale, we_n, re_n, dout, busy, cmd_done, ad_done, rd_valid},
          {22'd0, exp_pins(c || a, c, a, r, j)});
      chk($sformatf("vec%0d_chip_data_c%0d", idx, j), {16'd0, chip_dq}, {16'd0, v.exp_cd});
      chk($sformatf("vec%0d_rd_data_c%0d", idx, j), {16'd0, rd_data}, {16'd0, (j < 8) ? prev_rd : v.exp_rd});
    end
  endtask
  vec_t tv[7];
  logic [15:0] prev;
  bit seen;
  initial begin
    tv[0] = '{0, 8'hFF, 16'h0000, 16'h00FF, 16'h0000};
    tv[1] = '{1, 8'h20, 16'h0000, 16'h0020, 16'h0000};
    tv[2] = '{2, 8'h00, 16'h2C2C, 16'h0020, 16'h2C2C};
    tv[3] = '{3, 8'h90, 16'hBEEF, 16'h0090, 16'h2C2C};
    tv[4] = '{4, 8'hA5, 16'hBEEF, 16'h00A5, 16'h2C2C};
    tv[5] = '{2, 8'h00, 16'h1234, 16'h00A5, 16'h1234};
    tv[6] = '{5, 8'h30, 16'h0000, 16'h0030, 16'h1234};
    #12;
    chk("reset_pins", {22'd0, cs_n, cle, ale, we_n, re_n, dout, busy, cmd_done, ad_done, rd_valid}, {22'd0, 10'b1001100000});
    chk("reset_chip_data", {16'd0, chip_dq}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    chk("reset_ready", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      run_vec(tv[i], prev, i);
      prev = tv[i].exp_rd;
    end
    // rd request while busy is ignored
    cmd_req = 1'b1;
    cmd_d = 8'h70;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    seen = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 3) begin
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        j++;
        @(negedge clk);
      end
      if (j == 8) chk("busy_ign_cmd_done", {31'd0, cmd_done}, 32'd1);
      seen |= rd_valid;
    end
    chk("busy_ign_no_valid", {31'd0, seen}, 32'd0);
    chk("busy_ign_idle", {31'd0, busy}, 32'd0);
    chk("busy_ign_rd_data", {16'd0, rd_data}, 32'h1234);
    // reset during WE# low
    cmd_req = 1'b1;
    cmd_d = 8'h70;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    for (int j = 1; j <= 4; j++) @(negedge clk);
    chk("rst_mid_we_low", {31'd0, we_n}, 32'd0);
    rst_n = 1'b0;
    cmd_req = 1'b1;
    #1;
    chk("rst_mid_pins", {25'd0, cs_n, cle, ale, we_n, re_n, dout, busy}, {25'd0, 7'b1001100});
    chk("rst_mid_chip_data", {16'd0, chip_dq}, 32'd0);
    chk("rst_mid_rd_data", {16'd0, rd_data}, 32'd0);
    @(posedge clk);
    #1 cmd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      seen |= cmd_done | busy;
    end
    chk("rst_mid_no_done", {31'd0, seen}, 32'd0);
    run_vec(tv[0], 16'h0000, 7);
    // ready synchroniser delay
    @(negedge clk);
    chip_ready = 1'b1;
    @(negedge clk);
    chk("ready_rise_c1", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    chk("ready_rise_c2", {31'd0, rdy}, 32'd1);
    chip_ready = 1'b0;
    @(negedge clk);
    chk("ready_fall_c1", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    chk("ready_fall_c2", {31'd0, rdy}, 32'd0);
    // shortened timing instance: latency 5
    cmd_req = 1'b1;
    cmd_d = 8'h70;
    @(posedge clk);
    #1 cmd_req = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk($sformatf("fast_c%0d", j), {29'd0, f_we_n, f_cmd_done, f_busy}, {29'd0, j != 2, j == 5, j <= 4});
    end
    chk("fast_chip_data", {16'd0, f_chip_dq}, 32'h0070);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
